// File: rtl/shift_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq_pkg
// Purpose  : Shared encodings for shift_sequencer (ops, {s0,s1} modes, FSM).
// Revision : 1.0 - initial release
// ============================================================================
package shift_seq_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    // Mode is packed as {s0, s1}
    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_e;

endpackage : shift_seq_pkg
`default_nettype wire

// File: rtl/shift_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer_if
// Purpose  : Request, result and shift-register control bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface shift_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_data;
    logic [AMT_W-1:0] req_amount;
    logic [1:0]       req_op;

    logic             sr_enable;
    logic             sr_s0;
    logic             sr_s1;
    logic [WIDTH-1:0] sr_input;
    logic             sr_left_shift_input;
    logic             sr_right_shift_input;
    logic [WIDTH-1:0] sr_out;

    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] result_data;

    // Sequencer side
    modport slave (
        input  req_valid, req_data, req_amount, req_op, sr_out, result_ready,
        output req_ready, sr_enable, sr_s0, sr_s1, sr_input,
               sr_left_shift_input, sr_right_shift_input,
               result_valid, result_data
    );

    // Requester / shift-register / consumer side
    modport master (
        output req_valid, req_data, req_amount, req_op, sr_out, result_ready,
        input  req_ready, sr_enable, sr_s0, sr_s1, sr_input,
               sr_left_shift_input, sr_right_shift_input,
               result_valid, result_data
    );

endinterface : shift_sequencer_if
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Load/shift controller for uni_shift_register with valid/ready
//            request and result ports. Optional op counter: SHIFT_SEQ_STAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  wire logic          clock,
    input  wire logic          reset,
    shift_sequencer_if.slave   bus
`ifdef SHIFT_SEQ_STAT_EN
    ,
    output logic [15:0]        op_count
`endif
);

    state_e           r_state;
    state_e           w_next;
    logic [AMT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_data;
    logic [AMT_W-1:0] r_amount;
    logic [1:0]       r_op;

    logic             w_accept;
    logic             w_consume;
    logic [1:0]       w_mode;
    logic             w_enable;
    logic             w_left_in;
    logic             w_right_in;
    logic [WIDTH-1:0] w_sr_input;
    logic [WIDTH-1:0] w_result;
    logic             w_ready;
    logic             w_valid;

    assign w_accept  = (r_state == IDLE) && bus.req_valid;
    assign w_consume = (r_state == DONE) && bus.result_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_data   <= '0;
            r_amount <= '0;
            r_op     <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_data   <= bus.req_data;
                        r_amount <= bus.req_amount;
                        r_op     <= bus.req_op;
                    end
                end
                LOAD:    r_cnt <= r_amount;
                SHIFT:   r_cnt <= r_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next     = r_state;
        w_mode     = MODE_HOLD;
        w_enable   = 1'b0;
        w_left_in  = 1'b0;
        w_right_in = 1'b0;
        w_sr_input = '0;
        w_result   = '0;
        w_ready    = 1'b0;
        w_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (w_accept) w_next = LOAD;
            end
            LOAD: begin
                w_enable   = 1'b1;
                w_mode     = MODE_LOAD;
                w_sr_input = r_data;
                w_next     = (r_amount == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                w_enable = 1'b1;
                // Serial fill bit is the only output that looks at sr_out
                case (r_op)
                    OP_SLL: w_mode = MODE_LEFT;
                    OP_SRL: w_mode = MODE_RIGHT;
                    OP_SRA: begin
                        w_mode     = MODE_RIGHT;
                        w_right_in = bus.sr_out[WIDTH-1];
                    end
                    default: begin
                        w_mode     = MODE_RIGHT;
                        w_right_in = bus.sr_out[0];
                    end
                endcase
                if (r_cnt == AMT_W'(1)) w_next = DONE;
            end
            DONE: begin
                w_valid  = 1'b1;
                w_result = bus.sr_out;
                if (w_consume) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.req_ready            = w_ready;
    assign bus.sr_enable            = w_enable;
    assign bus.sr_s0                = w_mode[1];
    assign bus.sr_s1                = w_mode[0];
    assign bus.sr_input             = w_sr_input;
    assign bus.sr_left_shift_input  = w_left_in;
    assign bus.sr_right_shift_input = w_right_in;
    assign bus.result_valid         = w_valid;
    assign bus.result_data          = w_result;

`ifdef SHIFT_SEQ_STAT_EN
    logic [15:0] r_op_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)          r_op_count <= '0;
        else if (w_consume) r_op_count <= r_op_count + 16'd1;
    end

    assign op_count = r_op_count;
`endif

endmodule : shift_sequencer
`default_nettype wire

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Upstream controller for the 16-bit universal shift register `uni_shift_register` in the execute stage of the pipelined RISC datapath.
- Accepts one shift request per transaction: operand, amount and operation, over a valid/ready handshake.
- Drives the register's enable, s0/s1 mode and serial inputs: one load cycle, then one shift cycle per bit position.
- Consumes the register's parallel output and returns the result over a second valid/ready handshake.

Parameters:
- WIDTH, 16, operand/result width; must match the shift register width.
- AMT_W, 4, shift-amount width; equals log2(WIDTH).

Ports:
- clock  input  1  rising-edge clock, shared with the shift register.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_data  input  WIDTH  operand to shift.
- req_amount  input  AMT_W  shift count, 0..15.
- req_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- sr_enable  output  1  to shift register enable.
- sr_s0  output  1  to shift register s0.
- sr_s1  output  1  to shift register s1.
- sr_input  output  WIDTH  to shift register parallel Input.
- sr_left_shift_input  output  1  serial bit entering bit 0 on a left shift.
- sr_right_shift_input  output  1  serial bit entering bit 15 on a right shift.
- sr_out  input  WIDTH  shift register parallel Out.
- result_valid  output  1  result available.
- result_ready  input  1  consumer accepts the result.
- result_data  output  WIDTH  shifted value.

Behaviour:
- Shift register mode encoding ({s0,s1}):
  - 00 hold.
  - 10 right shift; sr_right_shift_input enters bit 15.
  - 01 left shift; sr_left_shift_input enters bit 0.
  - 11 parallel load.
- FSM states: IDLE, LOAD, SHIFT, DONE. All outputs are decoded from the state (Moore), except that the SHIFT serial bit is taken from the current sr_out.
- IDLE:
  - req_ready=1; sr_enable=0; result_valid=0.
  - On req_valid && req_ready: latch req_data, req_amount and req_op into internal registers, then go to LOAD.
- LOAD (exactly 1 cycle):
  - sr_enable=1, s0=1, s1=1, sr_input = latched data.
  - Next state: DONE if amount==0, else SHIFT with cnt = amount.
- SHIFT (exactly `amount` cycles):
  - sr_enable=1.
  - SLL: s0=0, s1=1, left_in=0.
  - SRL: s0=1, s1=0, right_in=0.
  - SRA: s0=1, s1=0, right_in=sr_out[15].
  - ROR: s0=1, s1=0, right_in=sr_out[0].
  - cnt decrements each cycle; on the cycle with cnt==1, go to DONE.
- DONE:
  - sr_enable=0 (register holds); result_valid=1; result_data=sr_out.
  - Go to IDLE on result_ready; stay in DONE (stable) otherwise.
- Outputs outside DONE: result_data=0. Serial inputs are 0 outside SHIFT. sr_input is 0 outside LOAD.
- Latency: a request accepted at edge T yields result_valid from cycle T+2+amount; amount=0 gives T+2.
- Throughput: one request per 3+amount cycles, assuming result_ready is held high.
- Ordering rules:
  - req_ready=0 in LOAD, SHIFT and DONE; requests during those states are not accepted.
  - No new request is accepted in the same cycle a result is consumed.
- Reset (asynchronous, any state, including mid-SHIFT):
  - State returns to IDLE and cnt and latched fields clear to 0.
  - sr_enable, sr_s0, sr_s1 and result_valid go to 0 immediately; req_ready=1 while in IDLE.
  - The in-flight result is discarded. Shift register contents are left untouched (that register has no reset).
- Reset values of the remaining outputs: sr_input=0, both serial inputs=0, result_data=0.

Optional Feature:
- Macro: SHIFT_SEQ_STAT_EN.
- Defined:
  - Adds output port op_count (16 bit), reset to 0.
  - Increments by 1 on each DONE→IDLE handshake and wraps from 0xFFFF to 0x0000.
  - Is not cleared by anything except reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package shift_seq_pkg holds:
  - op encodings SLL/SRL/SRA/ROR.
  - {s0,s1} mode constants MODE_HOLD/MODE_RIGHT/MODE_LEFT/MODE_LOAD.
  - FSM state encodings.
- Implementation stays flat: the down-counter is trivial and no sub-module is warranted.
- The top-level execute stage instantiates shift_sequencer and uni_shift_register side by side and wires the sr_* ports.

Test Plan:
- SLL, req_data=0xAAAA, amount=4:
  - exactly 1 cycle of {s0,s1}=11, then 4 cycles of 01 with left_in=0.
  - result_valid at T+6 with result_data=0xAAA0.
- SRA, 0x8001, amount=3 → result 0xF000; right_in=1 on every shift cycle.
- ROR:
  - 0x0001, amount=1 → 0x8000.
  - 0x0003, amount=15 → 0x0006.
- Boundary shifts:
  - SRL, 0x1234, amount=0 → no shift cycles; result 0x1234 at T+2.
  - SRL, 0xFFFF, amount=15 → 0x0001.
- Backpressure:
  - result_ready held low for 5 cycles → result_valid and result_data stay stable, sr_enable=0 and req_ready=0; a request presented then is ignored.
  - Raising result_ready → IDLE next cycle; op_count increments when SHIFT_SEQ_STAT_EN is defined.
- Reset mid-operation:
  - reset pulsed during the 2nd shift cycle of an amount=8 SLL → sr_enable, s0, s1 and result_valid go to 0 asynchronously, without waiting for a clock edge; req_ready=1 after release.
  - A fresh SRL 0x00F0 amount=4 then yields 0x000F.
